// File: rtl/e203_rvfi_pkg.sv
// Shared RVFI retire-packet types and field layout for the E203 trace/formal retire buffer.
// Field order is MSB-first: order, insn, pc_rdata, pc_wdata, rd_addr, rd_wdata, trap, intr.
package e203_rvfi_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned ILEN_DEF  = 32;
   localparam int unsigned ORDER_W   = 64;
   localparam int unsigned RD_ADDR_W = 5;

   typedef struct packed {
      logic [ORDER_W-1:0]   order;
      logic [ILEN_DEF-1:0]  insn;
      logic [XLEN_DEF-1:0]  pc_rdata;
      logic [XLEN_DEF-1:0]  pc_wdata;
      logic [RD_ADDR_W-1:0] rd_addr;
      logic [XLEN_DEF-1:0]  rd_wdata;
      logic                 trap;
      logic                 intr;
   } rvfi_pkt_t;

   localparam int unsigned RVFI_PKT_W = $bits(rvfi_pkt_t);

   // Bit offsets of each field within a default-width packet
   localparam int unsigned INTR_OFF     = 0;
   localparam int unsigned TRAP_OFF     = 1;
   localparam int unsigned RD_WDATA_OFF = 2;
   localparam int unsigned RD_ADDR_OFF  = RD_WDATA_OFF + XLEN_DEF;
   localparam int unsigned PC_WDATA_OFF = RD_ADDR_OFF + RD_ADDR_W;
   localparam int unsigned PC_RDATA_OFF = PC_WDATA_OFF + XLEN_DEF;
   localparam int unsigned INSN_OFF     = PC_RDATA_OFF + XLEN_DEF;
   localparam int unsigned ORDER_OFF    = INSN_OFF + ILEN_DEF;

   function automatic int unsigned pkt_width(input int unsigned xlen, input int unsigned ilen);
      return ORDER_W + ilen + 3 * xlen + RD_ADDR_W + 2;
   endfunction

endpackage

// File: rtl/e203_rvfi_compact.sv
// Combinational compactor: packs the valid retire channels into the low slots in ascending
// channel order and reports how many are valid.
module e203_rvfi_compact #(
   parameter int unsigned NRET  = 2,
   parameter int unsigned PKT_W = 199,
   parameter int unsigned CW    = $clog2(NRET + 1)
) (
   input  logic [NRET-1:0]       in_valid,
   input  logic [NRET*PKT_W-1:0] in_pkt,
   output logic [NRET*PKT_W-1:0] out_pkt,
   output logic [CW-1:0]         n_valid
);

   int unsigned k;

   always_comb begin
      out_pkt = '0;
      k       = 0;
      for (int i = 0; i < NRET; i++) begin
         if (in_valid[i]) begin
            out_pkt[k*PKT_W +: PKT_W] = in_pkt[i*PKT_W +: PKT_W];
            k = k + 1;
         end
      end
      n_valid = CW'(k);
   end

endmodule

// File: rtl/e203_rvfi_retire_buf.sv
// Multi-channel RVFI retirement buffer: all-or-nothing capture of each cycle's retire packets
// into an in-order FIFO, drained one per cycle. Optional order checker: RVFI_BUF_ORDER_CHK_EN.
module e203_rvfi_retire_buf
   import e203_rvfi_pkg::*;
#(
   parameter  int unsigned NRET  = 2,
   parameter  int unsigned XLEN  = 32,
   parameter  int unsigned ILEN  = 32,
   parameter  int unsigned DEPTH = 16,
   parameter  int unsigned CNT_W = 16,
   localparam int unsigned PKT_W = pkt_width(XLEN, ILEN),
   localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NRET-1:0]       in_valid,
   input  logic [NRET*PKT_W-1:0] in_pkt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PKT_W-1:0]      out_pkt,
   output logic [LW-1:0]         level,
   output logic                  overflow,
   output logic [CNT_W-1:0]      drop_cnt,
   input  logic                  clr
`ifdef RVFI_BUF_ORDER_CHK_EN
   ,
   output logic                  order_err
`endif
);

   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW        = $clog2(NRET + 1);
   localparam int unsigned SW        = CNT_W + CW;
   localparam int unsigned ORDER_LSB = PKT_W - ORDER_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PKT_W-1:0]      mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
   logic [SW-1:0]         drop_sum;
   logic [NRET*PKT_W-1:0] cpkt;
   logic [CW-1:0]         n;
   logic                  accept, drop, pop;

   e203_rvfi_compact #(
      .NRET  (NRET),
      .PKT_W (PKT_W),
      .CW    (CW)
   ) u_compact (
      .in_valid (in_valid),
      .in_pkt   (in_pkt),
      .out_pkt  (cpkt),
      .n_valid  (n)
   );

   // Free space is judged on the pre-pop level, so a same-cycle pop never makes room
   assign accept    = (32'(n) <= (DEPTH - 32'(level_q)));
   assign drop      = ~accept;
   assign out_valid = (level_q != '0);
   assign pop       = out_valid & out_ready;
   assign out_pkt   = mem_q[rd_ptr_q];
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

   always_comb begin
      level_d    = level_q + (accept ? LW'(n) : LW'(0)) - LW'(pop);
      wr_ptr_d   = wr_ptr_q + (accept ? AW'(n) : AW'(0));
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      drop_sum   = (clr ? SW'(0) : SW'(drop_cnt_q)) + SW'(n);
      if (drop) begin
         overflow_d = 1'b1;
         drop_cnt_d = (drop_sum > SW'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
      end else if (clr) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Payload storage needs no reset: nothing is visible until level is non-zero
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < NRET; i++) begin
            if (CW'(i) < n) begin
               mem_q[wr_ptr_q + AW'(i)] <= cpkt[i*PKT_W +: PKT_W];
            end
         end
      end
   end

`ifdef RVFI_BUF_ORDER_CHK_EN
   logic [ORDER_W-1:0] exp_q, exp_d, ord;
   logic               exp_vld_q, exp_vld_d, order_err_q, order_err_d;

   // Dropped packets are not checked but still move the expectation forward
   always_comb begin
      exp_d       = exp_q;
      exp_vld_d   = exp_vld_q;
      order_err_d = order_err_q;
      ord         = '0;
      if (clr) begin
         exp_vld_d   = 1'b0;
         order_err_d = 1'b0;
      end
      for (int i = 0; i < NRET; i++) begin
         if (CW'(i) < n) begin
            ord = cpkt[i*PKT_W + ORDER_LSB +: ORDER_W];
            if (accept && exp_vld_d && (ord != exp_d)) begin
               order_err_d = 1'b1;
            end
            exp_d     = ord + 64'd1;
            exp_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q       <= '0;
         exp_vld_q   <= 1'b0;
         order_err_q <= 1'b0;
      end else begin
         exp_q       <= exp_d;
         exp_vld_q   <= exp_vld_d;
         order_err_q <= order_err_d;
      end
   end

   assign order_err = order_err_q;
`endif

endmodule

// File: tb/tb_e203_rvfi_retire_buf.sv
// Self-checking bench for e203_rvfi_retire_buf: directed vector table, hand-written corner
// sequences and a randomised scoreboard run with a mid-stream reset.
module tb_e203_rvfi_retire_buf;
   import e203_rvfi_pkg::*;

   localparam int unsigned PKT_W = $bits(rvfi_pkt_t);

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [1:0]         in_valid = '0;
   logic [2*PKT_W-1:0] in_pkt = '0;
   logic               out_ready = 1'b0;
   logic               clr = 1'b0;

   logic               out_valid, out_valid2;
   logic [PKT_W-1:0]   out_pkt, out_pkt2;
   logic [4:0]         level, level2;
   logic               overflow, overflow2;
   logic [15:0]        drop_cnt;
   logic [1:0]         drop_cnt2;
`ifdef RVFI_BUF_ORDER_CHK_EN
   logic               order_err, order_err2;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   e203_rvfi_retire_buf u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_pkt    (in_pkt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pkt   (out_pkt),
      .level     (level),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .clr       (clr)
`ifdef RVFI_BUF_ORDER_CHK_EN
      ,
      .order_err (order_err)
`endif
   );

   e203_rvfi_retire_buf #(
      .CNT_W (2)
   ) u_dut_c2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_pkt    (in_pkt),
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .out_pkt   (out_pkt2),
      .level     (level2),
      .overflow  (overflow2),
      .drop_cnt  (drop_cnt2),
      .clr       (clr)
`ifdef RVFI_BUF_ORDER_CHK_EN
      ,
      .order_err (order_err2)
`endif
   );

   typedef struct {
      logic [1:0] iv;
      int         o0;
      int         o1;
      logic       rdy;
      logic       ev;
      int         lvl;
      int         eord;
   } vec_t;

   vec_t vecs[11];

   function automatic rvfi_pkt_t mk(input longint unsigned o);
      rvfi_pkt_t p;
      p.order    = o;
      p.insn     = o[31:0] ^ 32'h0000_0013;
      p.pc_rdata = 32'h8000_0000 + (o[31:0] << 2);
      p.pc_wdata = p.pc_rdata + 32'd4;
      p.rd_addr  = o[4:0];
      p.rd_wdata = ~o[31:0];
      p.trap     = o[0];
      p.intr     = o[1];
      return p;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] iv, input longint unsigned o0, input longint unsigned o1,
                        input logic rdy, input logic c);
      in_valid  = iv;
      in_pkt    = {mk(o1), mk(o0)};
      out_ready = rdy;
      clr       = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(2'b00, 0, 0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
   endtask

   int exp_q[$];
   int ord;
   int lvl_pre;
   int nn;
   int m_drop;
   logic m_ovf;
   logic m_pop;
   logic m_acc;
   logic [1:0] riv;
   logic rrdy;

   initial begin
      // iv, o0, o1, rdy, exp out_valid, exp level, exp head order
      vecs[0]  = '{2'b11, 0,  1,  1'b1, 1'b1, 2, 0};
      vecs[1]  = '{2'b00, 0,  0,  1'b1, 1'b1, 1, 1};
      vecs[2]  = '{2'b00, 0,  0,  1'b1, 1'b0, 0, 0};
      vecs[3]  = '{2'b10, 99, 5,  1'b0, 1'b1, 1, 5};
      vecs[4]  = '{2'b00, 0,  0,  1'b1, 1'b0, 0, 0};
      vecs[5]  = '{2'b01, 6,  0,  1'b0, 1'b1, 1, 6};
      vecs[6]  = '{2'b11, 7,  8,  1'b1, 1'b1, 2, 7};
      vecs[7]  = '{2'b00, 0,  0,  1'b0, 1'b1, 2, 7};
      vecs[8]  = '{2'b00, 0,  0,  1'b1, 1'b1, 1, 8};
      vecs[9]  = '{2'b00, 0,  0,  1'b1, 1'b0, 0, 0};
      vecs[10] = '{2'b00, 0,  0,  1'b1, 1'b0, 0, 0};

      #2;
      do_reset();
      chk("reset out_valid", out_valid, 0);
      chk("reset level", level, 0);
      chk("reset overflow", overflow, 0);
      chk("reset drop_cnt", drop_cnt, 0);
      tick();

      // Directed vectors: basic push, sparse channels, push with pop, empty pop
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].iv, vecs[i].o0, vecs[i].o1, vecs[i].rdy, 1'b0);
         tick();
         chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ev);
         chk($sformatf("vec%0d level", i), level, vecs[i].lvl);
         chk($sformatf("vec%0d overflow", i), overflow, 0);
         chk($sformatf("vec%0d drop_cnt", i), drop_cnt, 0);
         if (vecs[i].ev) chk($sformatf("vec%0d pkt", i), out_pkt, mk(vecs[i].eord));
      end

      // Near-full drop, full drop with pop, clr colliding with a drop
      do_reset();
      tick();
      for (int k = 0; k < 7; k++) begin
         drive(2'b11, 100 + 2 * k, 101 + 2 * k, 1'b0, 1'b0);
         tick();
      end
      drive(2'b01, 114, 0, 1'b0, 1'b0);
      tick();
      chk("fill level15", level, 15);
      drive(2'b11, 115, 116, 1'b1, 1'b0);
      tick();
      chk("drop15 level", level, 14);
      chk("drop15 overflow", overflow, 1);
      chk("drop15 drop_cnt", drop_cnt, 2);
      chk("drop15 head", out_pkt, mk(101));
      drive(2'b11, 117, 118, 1'b0, 1'b0);
      tick();
      chk("full level16", level, 16);
      drive(2'b01, 119, 0, 1'b1, 1'b0);
      tick();
      chk("full drop level", level, 15);
      chk("full drop_cnt", drop_cnt, 3);
      chk("full head", out_pkt, mk(102));
      drive(2'b11, 120, 121, 1'b0, 1'b1);
      tick();
      chk("clr+drop overflow", overflow, 1);
      chk("clr+drop drop_cnt", drop_cnt, 2);
      chk("clr+drop level", level, 15);
      drive(2'b00, 0, 0, 1'b0, 1'b1);
      tick();
      chk("clr overflow", overflow, 0);
      chk("clr drop_cnt", drop_cnt, 0);
      exp_q.delete();
      for (int e = 102; e <= 114; e++) exp_q.push_back(e);
      exp_q.push_back(117);
      exp_q.push_back(118);
      while (exp_q.size() != 0) begin
         chk("drain head", out_pkt, mk(exp_q.pop_front()));
         drive(2'b00, 0, 0, 1'b1, 1'b0);
         tick();
      end
      chk("drain level", level, 0);
      chk("drain out_valid", out_valid, 0);

      // Narrow drop counter saturation
      do_reset();
      tick();
      for (int k = 0; k < 8; k++) begin
         drive(2'b11, 2 * k, 2 * k + 1, 1'b0, 1'b0);
         tick();
      end
      chk("c2 level16", level2, 16);
      drive(2'b11, 40, 41, 1'b0, 1'b0);
      tick();
      chk("c2 drop 2", drop_cnt2, 2);
      drive(2'b11, 42, 43, 1'b0, 1'b0);
      tick();
      chk("c2 drop sat", drop_cnt2, 3);
      chk("wide drop 4", drop_cnt, 4);
      chk("c2 overflow", overflow2, 1);
      drive(2'b00, 0, 0, 1'b0, 1'b1);
      tick();
      chk("c2 clr drop", drop_cnt2, 0);
      chk("c2 clr overflow", overflow2, 0);
      chk("wide clr drop", drop_cnt, 0);

`ifdef RVFI_BUF_ORDER_CHK_EN
      do_reset();
      tick();
      drive(2'b01, 7, 0, 1'b1, 1'b0);
      tick();
      chk("ord 7", order_err, 0);
      drive(2'b01, 8, 0, 1'b1, 1'b0);
      tick();
      chk("ord 8", order_err, 0);
      drive(2'b01, 10, 0, 1'b1, 1'b0);
      tick();
      chk("ord 10 err", order_err, 1);
      drive(2'b00, 0, 0, 1'b1, 1'b1);
      tick();
      chk("ord clr", order_err, 0);
      drive(2'b11, 20, 22, 1'b1, 1'b0);
      tick();
      chk("ord intra-cycle err", order_err, 1);
`endif

      // Random push/pop against a scoreboard with a reset in the middle
      do_reset();
      tick();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      ord    = 1000;
      for (int i = 0; i < 300; i++) begin
         riv     = 2'($urandom_range(0, 3));
         rrdy    = ($urandom_range(0, 2) == 0);
         nn      = int'(riv[0]) + int'(riv[1]);
         lvl_pre = exp_q.size();
         m_pop   = (lvl_pre != 0) && rrdy;
         m_acc   = (nn <= 16 - lvl_pre);
         drive(riv, ord, ord + 1, rrdy, 1'b0);
         tick();
         if (m_pop) void'(exp_q.pop_front());
         if (m_acc) begin
            if (riv[0]) exp_q.push_back(ord);
            if (riv[1]) exp_q.push_back(ord + 1);
         end else begin
            m_ovf  = 1'b1;
            m_drop = m_drop + nn;
         end
         ord = ord + 2;
         chk("rnd level", level, exp_q.size());
         chk("rnd out_valid", out_valid, exp_q.size() != 0);
         chk("rnd overflow", overflow, m_ovf);
         chk("rnd drop_cnt", drop_cnt, m_drop);
         if (exp_q.size() != 0) chk("rnd pkt", out_pkt, mk(exp_q[0]));
         if (i == 150) begin
            drive(2'b00, 0, 0, 1'b0, 1'b0);
            rst_n = 1'b0;
            #1;
            chk("midrst out_valid", out_valid, 0);
            chk("midrst level", level, 0);
            chk("midrst overflow", overflow, 0);
            exp_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            #1;
            rst_n = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
